// File: rtl/core_bus_arb_if.sv
// Request/response bundle between three bus masters, the arbiter and one slave.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface core_bus_arb_if;
  logic        m0_req,   m1_req,   m2_req;
  logic [31:0] m0_addr,  m1_addr,  m2_addr;
  logic        m0_we,    m1_we,    m2_we;
  logic [31:0] m0_wdata, m1_wdata, m2_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb, m2_wstrb;
  logic        m0_gnt,   m1_gnt,   m2_gnt;
  logic        m0_ack,   m1_ack,   m2_ack;
  logic        m0_err,   m1_err,   m2_err;
  logic [31:0] m0_rdata, m1_rdata, m2_rdata;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ack;
  logic [31:0] s_rdata;

  modport slave (
    input  m0_req, m1_req, m2_req, m0_addr, m1_addr, m2_addr, m0_we, m1_we, m2_we,
    input  m0_wdata, m1_wdata, m2_wdata, m0_wstrb, m1_wstrb, m2_wstrb,
    output m0_gnt, m1_gnt, m2_gnt, m0_ack, m1_ack, m2_ack, m0_err, m1_err, m2_err,
    output m0_rdata, m1_rdata, m2_rdata,
    output s_req, s_addr, s_we, s_wdata, s_wstrb,
    input  s_ack, s_rdata
  );

  modport master (
    output m0_req, m1_req, m2_req, m0_addr, m1_addr, m2_addr, m0_we, m1_we, m2_we,
    output m0_wdata, m1_wdata, m2_wdata, m0_wstrb, m1_wstrb, m2_wstrb,
    input  m0_gnt, m1_gnt, m2_gnt, m0_ack, m1_ack, m2_ack, m0_err, m1_err, m2_err,
    input  m0_rdata, m1_rdata, m2_rdata,
    input  s_req, s_addr, s_we, s_wdata, s_wstrb,
    output s_ack, s_rdata
  );
endinterface

// File: rtl/core_bus_arb.sv
// Three-master single-slave bus arbiter: fixed priority m2 > m1 > m0 with m0 starvation
// override, one transaction in flight, BUSY timeout with error response.
module core_bus_arb #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  core_bus_arb_if.slave bus,
  output logic          hold_flag_out
);
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {Idle, Busy, Done} state_e;

  state_e      state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  starve_q, starve_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic        any_req, starve_hit;
  logic [1:0]  pick;
  logic        busy, done;
  logic [2:0]  gnt, ack;

  assign any_req    = bus.m0_req | bus.m1_req | bus.m2_req;
  assign starve_hit = ({29'b0, starve_q} >= STARVE_MAX);

  always_comb begin
    if (bus.m0_req && starve_hit) pick = 2'd0;
    else if (bus.m2_req)          pick = 2'd2;
    else if (bus.m1_req)          pick = 2'd1;
    else                          pick = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= Idle;
      win_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      Idle: begin
        if (any_req) begin
          state_d = Busy;
          win_d   = pick;
          tmo_d   = '0;
          unique case (pick)
            2'd2: begin
              addr_d = bus.m2_addr; we_d = bus.m2_we; wdata_d = bus.m2_wdata; wstrb_d = bus.m2_wstrb;
            end
            2'd1: begin
              addr_d = bus.m1_addr; we_d = bus.m1_we; wdata_d = bus.m1_wdata; wstrb_d = bus.m1_wstrb;
            end
            default: begin
              addr_d = bus.m0_addr; we_d = bus.m0_we; wdata_d = bus.m0_wdata; wstrb_d = bus.m0_wstrb;
            end
          endcase
          if (bus.m0_req) begin
            if (pick == 2'd0)           starve_d = '0;
            else if (starve_q != 3'd7)  starve_d = starve_q + 3'd1;
          end
        end
      end
      Busy: begin
        // A late ack on the timeout edge still wins over the error.
        if (bus.s_ack) begin
          state_d = Done;
          rdata_d = bus.s_rdata;
          err_d   = 1'b0;
        end else if (tmo_q == TmoLast) begin
          state_d = Done;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      Done:    state_d = Idle;
      default: state_d = Idle;
    endcase
    if (!bus.m0_req) starve_d = '0;
  end

  always_comb begin
    busy = (state_q == Busy);
    done = (state_q == Done);
    gnt  = busy ? (3'b001 << win_q) : 3'b000;
    ack  = done ? (3'b001 << win_q) : 3'b000;

    bus.s_req   = busy;
    bus.s_addr  = busy ? addr_q  : '0;
    bus.s_we    = busy & we_q;
    bus.s_wdata = busy ? wdata_q : '0;
    bus.s_wstrb = busy ? wstrb_q : '0;

    bus.m0_gnt   = gnt[0];
    bus.m1_gnt   = gnt[1];
    bus.m2_gnt   = gnt[2];
    bus.m0_ack   = ack[0];
    bus.m1_ack   = ack[1];
    bus.m2_ack   = ack[2];
    bus.m0_err   = ack[0] & err_q;
    bus.m1_err   = ack[1] & err_q;
    bus.m2_err   = ack[2] & err_q;
    bus.m0_rdata = ack[0] ? rdata_q : '0;
    bus.m1_rdata = ack[1] ? rdata_q : '0;
    bus.m2_rdata = ack[2] ? rdata_q : '0;

    hold_flag_out = bus.m1_req & ~ack[1];
  end
endmodule

// File: tb/tb_core_bus_arb.sv
// Randomized and directed bench for core_bus_arb against a transaction-level model.
module tb_core_bus_arb;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic hold_flag_out;

  core_bus_arb_if bus ();

  core_bus_arb #(
    .TIMEOUT   (TIMEOUT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .hold_flag_out(hold_flag_out)
  );

  always #5 clk = ~clk;

  // Master-side stimulus
  logic [2:0]  t_req = 3'b000;
  logic [31:0] t_addr  [3];
  logic [2:0]  t_we = 3'b000;
  logic [31:0] t_wdata [3];
  logic [3:0]  t_wstrb [3];

  assign bus.m0_req = t_req[0];  assign bus.m1_req = t_req[1];  assign bus.m2_req = t_req[2];
  assign bus.m0_addr = t_addr[0]; assign bus.m1_addr = t_addr[1]; assign bus.m2_addr = t_addr[2];
  assign bus.m0_we = t_we[0];    assign bus.m1_we = t_we[1];    assign bus.m2_we = t_we[2];
  assign bus.m0_wdata = t_wdata[0]; assign bus.m1_wdata = t_wdata[1]; assign bus.m2_wdata = t_wdata[2];
  assign bus.m0_wstrb = t_wstrb[0]; assign bus.m1_wstrb = t_wstrb[1]; assign bus.m2_wstrb = t_wstrb[2];

  logic [2:0]   ack_vec;
  logic [175:0] act_vec;
  assign ack_vec = {bus.m2_ack, bus.m1_ack, bus.m0_ack};
  assign act_vec = {bus.m2_gnt, bus.m1_gnt, bus.m0_gnt, bus.m2_ack, bus.m1_ack, bus.m0_ack,
                    bus.m2_err, bus.m1_err, bus.m0_err, bus.m2_rdata, bus.m1_rdata, bus.m0_rdata,
                    bus.s_req, bus.s_addr, bus.s_we, bus.s_wdata, bus.s_wstrb, hold_flag_out};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Slave responder: 0 = random acks (also outside BUSY), 1 = ack after sl_lat cycles, 2 = never
  int          sl_mode = 0;
  int          sl_lat  = 1;
  int          sl_cnt  = 0;
  logic [31:0] sl_data = 32'h0;
  initial begin
    bus.s_ack   = 1'b0;
    bus.s_rdata = 32'h0;
  end
  always @(negedge clk) begin
    #1;
    if (bus.s_req) sl_cnt++;
    else sl_cnt = 0;
    case (sl_mode)
      0: begin
        bus.s_ack   = ($urandom_range(0, 5) == 0);
        bus.s_rdata = $urandom;
      end
      1: begin
        bus.s_ack   = bus.s_req && (sl_cnt == sl_lat);
        bus.s_rdata = sl_data;
      end
      default: begin
        bus.s_ack   = 1'b0;
        bus.s_rdata = $urandom;
      end
    endcase
  end

  // Transaction-level reference: one transaction in flight, then one response cycle.
  bit          md_busy = 1'b0;
  bit          md_resp = 1'b0;
  int          md_age = 0, md_owner = 0, md_resp_owner = 0, md_losses = 0;
  logic [31:0] md_addr = '0, md_wdata = '0, md_resp_data = '0;
  logic        md_we = 1'b0, md_resp_err = 1'b0;
  logic [3:0]  md_wstrb = '0;

  function automatic int next_winner();
    if (t_req[0] && md_losses >= STARVE_MAX) return 0;
    for (int i = 2; i >= 0; i--) if (t_req[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_busy <= 1'b0;
      md_resp <= 1'b0;
    end else if (md_resp) begin
      md_resp <= 1'b0;
    end else if (md_busy) begin
      md_age <= md_age + 1;
      if (bus.s_ack || (md_age + 1 == TIMEOUT)) begin
        md_busy       <= 1'b0;
        md_resp       <= 1'b1;
        md_resp_owner <= md_owner;
        md_resp_err   <= !bus.s_ack;
        md_resp_data  <= bus.s_ack ? bus.s_rdata : 32'h0;
      end
    end else if (t_req != 3'b000) begin
      md_busy  <= 1'b1;
      md_age   <= 0;
      md_owner <= next_winner();
      md_addr  <= t_addr[next_winner()];
      md_we    <= t_we[next_winner()];
      md_wdata <= t_wdata[next_winner()];
      md_wstrb <= t_wstrb[next_winner()];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) md_losses <= 0;
    else if (!t_req[0]) md_losses <= 0;
    else if (!md_busy && !md_resp) md_losses <= (next_winner() == 0) ? 0 : md_losses + 1;
  end

  function automatic logic [175:0] model_out();
    logic [2:0]  g, a, e;
    logic [31:0] rd [3];
    logic        b;
    g = '0; a = '0; e = '0;
    for (int i = 0; i < 3; i++) rd[i] = '0;
    b = md_busy && !rst;
    if (!rst) begin
      if (md_busy) g[md_owner] = 1'b1;
      if (md_resp) begin
        a[md_resp_owner]  = 1'b1;
        e[md_resp_owner]  = md_resp_err;
        rd[md_resp_owner] = md_resp_data;
      end
    end
    return {g, a, e, rd[2], rd[1], rd[0], b, b ? md_addr : 32'h0, b & md_we,
            b ? md_wdata : 32'h0, b ? md_wstrb : 4'h0, t_req[1] & ~a[1]};
  endfunction

  always @(negedge clk) chk("model_cycle", act_vec, model_out());

  task automatic settle();
    t_req   = 3'b000;
    sl_mode = 1;
    sl_lat  = 1;
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int idx, input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (ack_vec[idx]) ok = 1'b1;
    end
  endtask

  initial begin
    int          cyc, busy_n, rise_n, ack_n, m0_at;
    bit          ok, prev;
    int          rise_at [3], ack_at [3], ack_who [3];
    logic [31:0] rise_addr [3];
    logic [31:0] exp_addr [3];

    for (int i = 0; i < 3; i++) begin
      t_addr[i] = '0; t_wdata[i] = '0; t_wstrb[i] = '0;
      rise_at[i] = 0; ack_at[i] = 0; ack_who[i] = -1; rise_addr[i] = '0;
    end
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h2000; exp_addr[2] = 32'h3000;

    // Reset: all outputs low, hold still follows m1_req, random slave acks ignored
    rst   = 1'b1;
    t_req = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_outputs", act_vec, 176'h1);
    #1 rst = 1'b0;
    settle();

    // Single read by m1
    sl_lat = 2; sl_data = 32'hDEADBEEF;
    t_req[1] = 1'b1; t_addr[1] = 32'h100; t_we[1] = 1'b0; t_wstrb[1] = 4'hF;
    @(negedge clk);
    chk("read_s_req", bus.s_req, 1);
    chk("read_s_addr", bus.s_addr, 32'h100);
    chk("read_gnt", {bus.m2_gnt, bus.m1_gnt, bus.m0_gnt}, 3'b010);
    chk("read_hold_wait", hold_flag_out, 1);
    wait_ack(1, 10, cyc, ok);
    chk("read_ack_seen", ok, 1);
    chk("read_ack_latency", cyc, 2);
    chk("read_rdata", bus.m1_rdata, 32'hDEADBEEF);
    chk("read_err", bus.m1_err, 0);
    chk("read_hold_on_ack", hold_flag_out, 0);
    #1 t_req[1] = 1'b0;
    @(negedge clk);
    chk("read_ack_one_cycle", bus.m1_ack, 0);
    chk("read_rdata_zero", bus.m1_rdata, 0);
    settle();

    // Contention: m2, m1, m0 in turn with an idle cycle between
    for (int i = 0; i < 3; i++) t_addr[i] = exp_addr[i];
    t_req = 3'b111; prev = 1'b0; rise_n = 0; ack_n = 0;
    for (int c = 1; c <= 40 && ack_n < 3; c++) begin
      @(negedge clk);
      if (bus.s_req && !prev && rise_n < 3) begin
        rise_at[rise_n] = c; rise_addr[rise_n] = bus.s_addr; rise_n++;
      end
      prev = bus.s_req;
      if (ack_vec != 3'b000) begin
        ack_at[ack_n]  = c;
        ack_who[ack_n] = ack_vec[2] ? 2 : (ack_vec[1] ? 1 : 0);
        ack_n++;
        #1 t_req = t_req & ~ack_vec;
      end
    end
    chk("contend_acks", ack_n, 3);
    for (int k = 0; k < 3; k++) begin
      chk("contend_order", ack_who[k], 2 - k);
      chk("contend_s_addr", rise_addr[k], exp_addr[2 - k]);
      if (k > 0) chk("contend_gap", rise_at[k] - ack_at[k - 1], 2);
    end
    settle();

    // Starvation: m0 wins the 5th arbitration against a persistent m1
    t_req = 3'b011; prev = 1'b0; rise_n = 0; m0_at = 0;
    for (int c = 1; c <= 80 && m0_at == 0; c++) begin
      @(negedge clk);
      if (bus.s_req && !prev) begin
        rise_n++;
        if (bus.m0_gnt) m0_at = rise_n;
      end
      prev = bus.s_req;
    end
    chk("starve_m0_arb", m0_at, 5);
    #1 settle();

    // Timeout on m2: 16 BUSY cycles then error response
    sl_mode = 2; t_req = 3'b100; t_addr[2] = 32'h200;
    busy_n = 0; ok = 1'b0;
    for (int c = 1; c <= 40 && !ok; c++) begin
      @(negedge clk);
      if (bus.s_req) busy_n++;
      if (bus.m2_ack) ok = 1'b1;
    end
    chk("tmo_ack_seen", ok, 1);
    chk("tmo_busy_cycles", busy_n, 16);
    chk("tmo_err", bus.m2_err, 1);
    chk("tmo_rdata", bus.m2_rdata, 0);
    chk("tmo_s_req_low", bus.s_req, 0);
    #1 settle();

    // Reset during the 3rd BUSY cycle
    sl_mode = 2; t_req = 3'b010; t_addr[1] = 32'h44;
    busy_n = 0;
    for (int c = 1; c <= 10 && busy_n < 3; c++) begin
      @(negedge clk);
      if (bus.s_req) busy_n++;
    end
    chk("rst_busy3", busy_n, 3);
    #1 rst = 1'b1;
    #1;
    chk("rst_s_req_drop", bus.s_req, 0);
    chk("rst_gnt_drop", bus.m1_gnt, 0);
    chk("rst_hold", hold_flag_out, 1);
    t_req = 3'b000;
    @(negedge clk);
    chk("rst_no_ack", ack_vec, 0);
    #1 rst = 1'b0;
    sl_mode = 1; sl_lat = 1; sl_data = 32'hCAFE0001;
    t_req = 3'b001; t_addr[0] = 32'h80;
    wait_ack(0, 10, cyc, ok);
    chk("post_rst_ack_seen", ok, 1);
    chk("post_rst_latency", cyc, 2);
    chk("post_rst_ack_owner", ack_vec, 3'b001);
    chk("post_rst_rdata", bus.m0_rdata, 32'hCAFE0001);
    #1 settle();

    // Random traffic with random slave acks and occasional resets
    sl_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) t_req[i] = ~t_req[i];
        t_addr[i]  = $urandom;
        t_wdata[i] = $urandom;
        t_we[i]    = 1'($urandom_range(0, 1));
        t_wstrb[i] = 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0;
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
